// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-cycle controller: keypad M:SS entry, start/stop/clear/door
// state machine and 1 Hz countdown driving the magnetron and done indicator.
module microwave_timer_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DONE_TICKS  = 3
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       mag_on,
    output logic       Enablen,
    output logic       done
);

    localparam int CW = $clog2(DONE_TICKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_COOK, S_PAUSE, S_DONE} state_t;

    state_t state_q, state_d;

    // bit 0 is the door level; bits 5:1 are edge-detected against sync_prev
    logic [5:0]                  raw_in, synced;
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [4:0]                  sync_prev;

    assign raw_in = {pgt_1Hz, clearn, stopn, startn, loadn, door_closed};
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            sync_q    <= '0;
            sync_prev <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            sync_prev <= synced[5:1];
        end
    end

    logic door, key, start, stop, clr, tick;

    assign door  = synced[0];
    assign key   = sync_prev[0] & ~synced[1];
    assign start = sync_prev[1] & ~synced[2];
    assign stop  = sync_prev[2] & ~synced[3];
    assign clr   = sync_prev[3] & ~synced[4];
    assign tick  = ~sync_prev[4] & synced[5];

    logic [3:0]    ones_d, tens_d, mins_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          key_ok, at_one;

    assign key_ok = (D <= 4'd9) && (sec_ones <= 4'd5);
    assign at_one = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    always_comb begin
        state_d = state_q;
        ones_d  = sec_ones;
        tens_d  = sec_tens;
        mins_d  = min_ones;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE, S_SETUP: begin
                if (clr) begin
                    state_d = S_IDLE;
                    ones_d  = '0;
                    tens_d  = '0;
                    mins_d  = '0;
                end else if (state_q == S_SETUP && start && door) begin
                    state_d = S_COOK;
                end else if (key && key_ok) begin
                    mins_d  = sec_tens;
                    tens_d  = sec_ones;
                    ones_d  = D;
                    // a shift that lands on 0:00 falls back to IDLE so COOK never starts at zero
                    state_d = ({sec_tens, sec_ones, D} != 12'd0) ? S_SETUP : S_IDLE;
                end
            end
            S_COOK: begin
                if (clr) begin
                    state_d = S_IDLE;
                    ones_d  = '0;
                    tens_d  = '0;
                    mins_d  = '0;
                end else if (!door || stop) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (sec_ones == 4'd0) begin
                        ones_d = 4'd9;
                        if (sec_tens == 4'd0) begin
                            tens_d = 4'd5;
                            mins_d = min_ones - 4'd1;
                        end else begin
                            tens_d = sec_tens - 4'd1;
                        end
                    end else begin
                        ones_d = sec_ones - 4'd1;
                    end
                    if (at_one) begin
                        state_d = S_DONE;
                        dcnt_d  = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (clr || stop) begin
                    state_d = S_IDLE;
                    ones_d  = '0;
                    tens_d  = '0;
                    mins_d  = '0;
                end else if (start && door) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (clr || start || key) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (dcnt_q == CW'(DONE_TICKS - 1))
                        state_d = S_IDLE;
                    else
                        dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sec_ones <= ones_d;
            sec_tens <= tens_d;
            min_ones <= mins_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // decoded from the state register so reset drops the magnetron asynchronously
    assign mag_on  = (state_q == S_COOK);
    assign Enablen = (state_q == S_COOK) || (state_q == S_PAUSE) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);

endmodule
